// File: rtl/tt_sweep_ctrl.sv
// Exhaustive input sweep controller: drives all 16 four-bit vectors into a
// combinational block, holds each for DWELL cycles, and captures the 3-bit result.
module tt_sweep_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] x_out,
  input  logic [2:0] dut_y,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  input  logic [3:0] rd_addr,
  output logic [2:0] rd_data,
  output logic       rd_valid
);

  localparam int CW = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_vec;
  logic [3:0]    r_x;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_tab [16];
  logic [15:0]   r_valid;
  logic          r_aborted;

  logic w_accept;
  logic w_abort;
  logic w_capture;
  logic w_last;

  // Abort outranks capture, so a capture is only qualified when abort is low.
  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_abort   = (r_state == S_DRIVE) && abort;
  assign w_capture = (r_state == S_DRIVE) && !abort && (r_cnt == LAST);
  assign w_last    = w_capture && (r_vec == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_DRIVE;
      S_DRIVE: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_DRIVE: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec     <= 4'd0;
      r_x       <= 4'd0;
      r_cnt     <= '0;
      r_valid   <= 16'd0;
      r_aborted <= 1'b0;
    end else if (w_accept) begin
      r_vec     <= 4'd0;
      r_x       <= 4'd0;
      r_cnt     <= '0;
      r_valid   <= 16'd0;
      r_aborted <= 1'b0;
    end else if (w_abort) begin
      r_vec     <= 4'd0;
      r_x       <= 4'd0;
      r_cnt     <= '0;
      r_aborted <= 1'b1;
    end else if (r_state == S_DRIVE) begin
      if (w_capture) begin
        r_valid[r_vec] <= 1'b1;
        r_cnt          <= '0;
        // The last vector parks vec at 15 rather than letting it wrap.
        if (r_vec == 4'hF) begin
          r_x <= 4'd0;
        end else begin
          r_vec <= r_vec + 4'd1;
          r_x   <= r_vec + 4'd1;
        end
      end else begin
        r_cnt <= r_cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_tab[i] <= 3'd0;
      end
    end else if (w_capture) begin
      r_tab[r_vec] <= dut_y;
    end
  end

  assign x_out    = r_x;
  assign aborted  = r_aborted;
  assign rd_data  = r_tab[rd_addr];
  assign rd_valid = r_valid[rd_addr];

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Randomized bench for tt_sweep_ctrl: two instances (DWELL=4 and DWELL=1) checked
// against a timing model derived from the sweep schedule and a stub-based result table.
module tb_tt_sweep_ctrl;

  localparam int D4 = 4;
  localparam int D1 = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, abort4, start1, abort1;
  logic [3:0] x4, x1, rd_addr4, rd_addr1;
  logic [2:0] y4, y1, rd_data4, rd_data1, mask4, mask1;
  logic       busy4, done4, aborted4, rd_valid4;
  logic       busy1, done1, aborted1, rd_valid1;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_tab4 [16];
  logic [2:0] exp_tab1 [16];
  logic       exp_ab4;

  always #5 clk = ~clk;

  function automatic logic [2:0] stub(input logic [3:0] v);
    return {v[3] & v[2], v[1] | v[0], v[3] ^ v[0]};
  endfunction

  assign y4 = stub(x4) ^ mask4;
  assign y1 = stub(x1) ^ mask1;

  tt_sweep_ctrl #(.DWELL(D4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .x_out(x4), .dut_y(y4),
    .busy(busy4), .done(done4), .aborted(aborted4), .rd_addr(rd_addr4),
    .rd_data(rd_data4), .rd_valid(rd_valid4)
  );

  tt_sweep_ctrl #(.DWELL(D1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .x_out(x1), .dut_y(y1),
    .busy(busy1), .done(done1), .aborted(aborted1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .rd_valid(rd_valid1)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    total++;
    if ({busy4, done4, aborted4, x4} !== 7'd0) begin
      bad++;
      $display("FAIL reset_ctrl4 got=%b exp=%b", {busy4, done4, aborted4, x4}, 7'd0);
    end
    total++;
    if ({busy1, done1, aborted1, x1} !== 7'd0) begin
      bad++;
      $display("FAIL reset_ctrl1 got=%b exp=%b", {busy1, done1, aborted1, x1}, 7'd0);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr4 = 4'(a);
      rd_addr1 = 4'(a);
      #1;
      total++;
      if ({rd_valid4, rd_data4, rd_valid1, rd_data1} !== 8'd0) begin
        bad++;
        $display("FAIL reset_table addr=%0d got=%b exp=%b", a,
                 {rd_valid4, rd_data4, rd_valid1, rd_data1}, 8'd0);
      end
    end
    for (int i = 0; i < 16; i++) begin
      exp_tab4[i] = 3'd0;
      exp_tab1[i] = 3'd0;
    end
    exp_ab4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full DWELL=4 sweep; optional extra start pulse at sweep time extra_t.
  task automatic run_sweep4(input int extra_t, input int tail);
    int ncap;
    logic [6:0] e;
    mask4  = 3'($urandom);
    start4 = 1'b1;
    @(negedge clk);
    start4  = 1'b0;
    exp_ab4 = 1'b0;
    for (int t = 0; t <= 16 * D4 + tail; t++) begin
      if (t > 0 && t % D4 == 0 && t <= 16 * D4)
        exp_tab4[t / D4 - 1] = stub(4'(t / D4 - 1)) ^ mask4;
      ncap = (t / D4 > 16) ? 16 : t / D4;
      e = {t < 16 * D4, t == 16 * D4, 1'b0, (t < 16 * D4) ? 4'(t / D4) : 4'd0};
      total++;
      if ({busy4, done4, aborted4, x4} !== e) begin
        bad++;
        $display("FAIL sweep4_ctrl t=%0d got=%b exp=%b", t, {busy4, done4, aborted4, x4}, e);
      end
      rd_addr4 = 4'($urandom);
      #1;
      total++;
      if ({rd_valid4, rd_data4} !== {int'(rd_addr4) < ncap, exp_tab4[rd_addr4]}) begin
        bad++;
        $display("FAIL sweep4_read t=%0d addr=%0d got=%b exp=%b", t, rd_addr4,
                 {rd_valid4, rd_data4}, {int'(rd_addr4) < ncap, exp_tab4[rd_addr4]});
      end
      start4 = (t == extra_t);
      @(negedge clk);
    end
    start4 = 1'b0;
    for (int a = 9; a <= 12; a += 3) begin
      rd_addr4 = 4'(a);
      #1;
      total++;
      if ({rd_valid4, rd_data4} !== {1'b1, stub(4'(a)) ^ mask4}) begin
        bad++;
        $display("FAIL sweep4_entry addr=%0d got=%b exp=%b", a, {rd_valid4, rd_data4},
                 {1'b1, stub(4'(a)) ^ mask4});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    run_sweep4(3 * D4 + int'($urandom_range(0, D4 - 1)), 4);
  endtask

  // Abort raised while vec==v, j cycles into its dwell.
  task automatic test_abort(input int v, input int j);
    int ta;
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    total++;
    if ({busy4, done4, aborted4, x4} !== {2'b00, exp_ab4, 4'd0}) begin
      bad++;
      $display("FAIL abort_idle got=%b exp=%b", {busy4, done4, aborted4, x4}, {2'b00, exp_ab4, 4'd0});
    end
    mask4  = mask4 ^ 3'b111;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    ta = v * D4 + j;
    for (int t = 0; t <= ta; t++) begin
      if (t > 0 && t % D4 == 0)
        exp_tab4[t / D4 - 1] = stub(4'(t / D4 - 1)) ^ mask4;
      total++;
      if ({busy4, done4, aborted4, x4} !== {3'b100, 4'(t / D4)}) begin
        bad++;
        $display("FAIL abort_run t=%0d got=%b exp=%b", t, {busy4, done4, aborted4, x4},
                 {3'b100, 4'(t / D4)});
      end
      abort4 = (t == ta);
      @(negedge clk);
    end
    abort4  = 1'b0;
    exp_ab4 = 1'b1;
    total++;
    if ({busy4, done4, aborted4, x4} !== 7'b0010000) begin
      bad++;
      $display("FAIL abort_exit v=%0d j=%0d got=%b exp=%b", v, j, {busy4, done4, aborted4, x4},
               7'b0010000);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr4 = 4'(a);
      #1;
      total++;
      if ({rd_valid4, rd_data4} !== {a < v, exp_tab4[a]}) begin
        bad++;
        $display("FAIL abort_table v=%0d addr=%0d got=%b exp=%b", v, a, {rd_valid4, rd_data4},
                 {a < v, exp_tab4[a]});
      end
    end
    @(negedge clk);
    for (int t = 0; t < 16 * D4 + 4; t++) begin
      total++;
      if ({busy4, done4, aborted4, x4} !== 7'b0010000) begin
        bad++;
        $display("FAIL abort_quiet t=%0d got=%b exp=%b", t, {busy4, done4, aborted4, x4}, 7'b0010000);
      end
      @(negedge clk);
    end
  endtask

  // DWELL=1 with start held: sweeps repeat every 18 cycles (16 DRIVE, DONE, IDLE).
  task automatic test_back_to_back;
    int p, ncap;
    logic [6:0] e;
    mask1  = 3'($urandom);
    start1 = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 60; t++) begin
      p = (t < 54) ? t % 18 : 17;
      if (t < 54 && p >= 1 && p <= 16)
        exp_tab1[p - 1] = stub(4'(p - 1)) ^ mask1;
      ncap = (p > 16) ? 16 : p;
      e = {p < 16, p == 16, 1'b0, (p < 16) ? 4'(p) : 4'd0};
      total++;
      if ({busy1, done1, aborted1, x1} !== e) begin
        bad++;
        $display("FAIL b2b_ctrl t=%0d got=%b exp=%b", t, {busy1, done1, aborted1, x1}, e);
      end
      rd_addr1 = 4'($urandom);
      #1;
      total++;
      if ({rd_valid1, rd_data1} !== {int'(rd_addr1) < ncap, exp_tab1[rd_addr1]}) begin
        bad++;
        $display("FAIL b2b_read t=%0d addr=%0d got=%b exp=%b", t, rd_addr1,
                 {rd_valid1, rd_data1}, {int'(rd_addr1) < ncap, exp_tab1[rd_addr1]});
      end
      if (t == 39) start1 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    mask4  = 3'($urandom);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (7 * D4 + int'($urandom_range(0, D4 - 1))) @(negedge clk);
    total++;
    if (x4 !== 4'd7) begin
      bad++;
      $display("FAIL rstmid_pre got=%0d exp=%0d", x4, 7);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy4, done4, aborted4, x4} !== 7'd0) begin
      bad++;
      $display("FAIL rstmid_ctrl got=%b exp=%b", {busy4, done4, aborted4, x4}, 7'd0);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr4 = 4'(a);
      rd_addr1 = 4'(a);
      #0.5;
      total++;
      if ({rd_valid4, rd_data4, rd_valid1, rd_data1} !== 8'd0) begin
        bad++;
        $display("FAIL rstmid_table addr=%0d got=%b exp=%b", a,
                 {rd_valid4, rd_data4, rd_valid1, rd_data1}, 8'd0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 16 * D4 + 8; t++) begin
      @(negedge clk);
      total++;
      if ({busy4, done4, x4} !== 6'd0) begin
        bad++;
        $display("FAIL rstmid_after t=%0d got=%b exp=%b", t, {busy4, done4, x4}, 6'd0);
      end
    end
  endtask

  initial begin
    start4 = 1'b0; abort4 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    rd_addr4 = 4'd0; rd_addr1 = 4'd0; mask4 = 3'd0; mask1 = 3'd0;
    test_reset;
    run_sweep4(-1, 6);
    test_start_ignored;
    test_abort(5, int'($urandom_range(0, D4 - 1)));
    run_sweep4(-1, 2);
    test_abort(15, D4 - 1);
    test_abort(int'($urandom_range(0, 15)), int'($urandom_range(0, D4 - 1)));
    run_sweep4(-1, 2);
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
